alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Sequencer that drives an external add/subtract accumulator to multiply by repeated addition
// and divide by repeated subtraction. Define ALU_SEQ_DIV_EN to build the divide path.
module alu_seq_ctrl #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         START,
  input  logic         OP,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] ACC_Q,
  output logic [W-1:0] ACC_B,
  output logic         ACC_E,
  output logic         ACC_S,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] RESULT,
  output logic [W-1:0] REM,
  output logic         OVF,
  output logic         ERR
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MUL   = 3'd2,
    S_DONE  = 3'd3
`ifdef ALU_SEQ_DIV_EN
    ,
    S_LOAD  = 3'd4,
    S_DIV   = 3'd5
`endif
  } state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  state_t       state;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic         op_r;
  logic [W-1:0] cnt;
  logic [W:0]   mul_sum;

  // Width-extended sum exposes the carry that marks a product overflow.
  assign mul_sum = {1'b0, ACC_Q} + {1'b0, a_r};

`ifdef ALU_SEQ_DIV_EN
  logic div_ge;
  assign div_ge = (ACC_Q >= b_r);
`endif

  always_comb begin
    ACC_E = 1'b0;
    ACC_S = 1'b0;
    ACC_B = '0;
    case (state)
      S_CLEAR: begin
        ACC_E = 1'b1;
        ACC_S = 1'b1;
        ACC_B = ACC_Q;
      end
      S_MUL: begin
        ACC_E = 1'b1;
        ACC_B = a_r;
      end
`ifdef ALU_SEQ_DIV_EN
      S_LOAD: begin
        ACC_E = 1'b1;
        ACC_B = a_r;
      end
      S_DIV: begin
        if (div_ge) begin
          ACC_E = 1'b1;
          ACC_S = 1'b1;
          ACC_B = b_r;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      op_r   <= 1'b0;
      cnt    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
      REM    <= '0;
      OVF    <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            a_r  <= A;
            b_r  <= B;
            op_r <= OP;
            cnt  <= '0;
            OVF  <= 1'b0;
            ERR  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            if (OP && (B == '0)) begin
`else
            if (OP) begin
`endif
              // Rejected request: report at once without touching the accumulator.
              ERR    <= 1'b1;
              RESULT <= '0;
              REM    <= '0;
              DONE   <= 1'b1;
              state  <= S_DONE;
            end else begin
              BUSY  <= 1'b1;
              state <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          if (!op_r && (b_r == '0)) begin
            RESULT <= '0;
            REM    <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            state  <= S_DONE;
          end else if (!op_r) begin
            state <= S_MUL;
          end else begin
`ifdef ALU_SEQ_DIV_EN
            state <= S_LOAD;
`else
            ERR    <= 1'b1;
            RESULT <= '0;
            REM    <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            state  <= S_DONE;
`endif
          end
        end
        S_MUL: begin
          if (mul_sum[W]) OVF <= 1'b1;
          cnt <= cnt + ONE;
          // The last add lands on this edge, so capture the sum rather than ACC_Q.
          if (cnt == b_r - ONE) begin
            RESULT <= mul_sum[W-1:0];
            REM    <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            state  <= S_DONE;
          end
        end
`ifdef ALU_SEQ_DIV_EN
        S_LOAD: begin
          state <= S_DIV;
        end
        S_DIV: begin
          if (div_ge) begin
            cnt <= cnt + ONE;
          end else begin
            RESULT <= cnt;
            REM    <= ACC_Q;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
            state  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural accumulator; covers the divide path
// only when ALU_SEQ_DIV_EN is defined, otherwise checks that divide requests are rejected.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] acc_q = 8'h5A;
  logic [7:0] acc_b;
  logic       acc_e;
  logic       acc_s;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] rem;
  logic       ovf;
  logic       err;

  int errors = 0;
  int checks = 0;
  int lat;
  int ecnt;
  logic [7:0] acc_before;

  alu_seq_ctrl #(.W(8)) dut (
    .CLK(clk), .CLR(clr), .START(start), .OP(op), .A(a), .B(b), .ACC_Q(acc_q),
    .ACC_B(acc_b), .ACC_E(acc_e), .ACC_S(acc_s), .BUSY(busy), .DONE(done),
    .RESULT(result), .REM(rem), .OVF(ovf), .ERR(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (acc_e) acc_q <= acc_s ? (acc_q - acc_b) : (acc_q + acc_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic o, input logic [7:0] av, input logic [7:0] bv, input bit hold);
    repeat (2) @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    if (!hold) begin
      start = 1'b0; a = ~av; b = ~bv; op = ~o;
    end
  endtask

  task automatic wait_done(input int k0, output int l, output int ec);
    int  k;
    bit  seen;
    l = -1; ec = 0; k = k0; seen = 0;
    while (!seen && k < k0 + 300) begin
      if (acc_e) ec++;
      if (done) begin
        l = k;
        seen = 1;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_rem"}, rem, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_acc_e"}, acc_e, 0);
    chk({tag, "_acc_s"}, acc_s, 0);
    chk({tag, "_acc_b"}, acc_b, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    clr = 1'b0;

    // 10 * 6: clear plus six adds
    start_op(1'b0, 8'd10, 8'd6, 1'b0);
    wait_done(1, lat, ecnt);
    chk("mul10x6_lat", lat, 8);
    chk("mul10x6_ecnt", ecnt, 7);
    chk("mul10x6_result", result, 60);
    chk("mul10x6_ovf", ovf, 0);
    chk("mul10x6_rem", rem, 0);
    chk("mul10x6_acc", acc_q, 60);
    repeat (3) @(posedge clk); #1;
    chk("hold_result", result, 60);
    chk("hold_done", done, 0);
    chk("hold_busy", busy, 0);

    // 20 * 13 = 260 wraps to 4
    start_op(1'b0, 8'd20, 8'd13, 1'b0);
    wait_done(1, lat, ecnt);
    chk("mul20x13_lat", lat, 15);
    chk("mul20x13_result", result, 4);
    chk("mul20x13_ovf", ovf, 1);

    // multiply by zero
    start_op(1'b0, 8'd9, 8'd0, 1'b0);
    wait_done(1, lat, ecnt);
    chk("mulb0_lat", lat, 2);
    chk("mulb0_ecnt", ecnt, 1);
    chk("mulb0_result", result, 0);
    chk("mulb0_ovf", ovf, 0);

    // 255 * 1 reaches the top without overflowing
    start_op(1'b0, 8'd255, 8'd1, 1'b0);
    wait_done(1, lat, ecnt);
    chk("mul255x1_lat", lat, 3);
    chk("mul255x1_result", result, 255);
    chk("mul255x1_ovf", ovf, 0);

`ifdef ALU_SEQ_DIV_EN
    start_op(1'b1, 8'd60, 8'd12, 1'b0);
    wait_done(1, lat, ecnt);
    chk("div60_12_lat", lat, 9);
    chk("div60_12_ecnt", ecnt, 7);
    chk("div60_12_result", result, 5);
    chk("div60_12_rem", rem, 0);
    chk("div60_12_err", err, 0);

    start_op(1'b1, 8'd100, 8'd7, 1'b0);
    wait_done(1, lat, ecnt);
    chk("div100_7_lat", lat, 18);
    chk("div100_7_result", result, 14);
    chk("div100_7_rem", rem, 2);

    start_op(1'b1, 8'd5, 8'd9, 1'b0);
    wait_done(1, lat, ecnt);
    chk("div5_9_lat", lat, 4);
    chk("div5_9_result", result, 0);
    chk("div5_9_rem", rem, 5);
`else
    acc_before = acc_q;
    start_op(1'b1, 8'd60, 8'd12, 1'b0);
    wait_done(1, lat, ecnt);
    chk("nodiv_lat", lat, 1);
    chk("nodiv_err", err, 1);
    chk("nodiv_ecnt", ecnt, 0);
    chk("nodiv_result", result, 0);
    chk("nodiv_rem", rem, 0);
    chk("nodiv_acc", acc_q, acc_before);
`endif

    // divide by zero
    acc_before = acc_q;
    start_op(1'b1, 8'd5, 8'd0, 1'b0);
    wait_done(1, lat, ecnt);
    chk("divz_lat", lat, 1);
    chk("divz_err", err, 1);
    chk("divz_ecnt", ecnt, 0);
    chk("divz_result", result, 0);
    chk("divz_acc", acc_q, acc_before);

    // START held high through a multiply: ignored while busy, re-accepted on first IDLE cycle
    start_op(1'b0, 8'd7, 8'd5, 1'b1);
    wait_done(1, lat, ecnt);
    chk("held_lat", lat, 7);
    chk("held_result", result, 35);
    chk("held_err", err, 0);
    @(posedge clk); #1;
    chk("held_idle_busy", busy, 0);
    @(posedge clk); #1;
    chk("held_reaccept_busy", busy, 1);
    start = 1'b0; a = 8'd0; b = 8'd0;
    wait_done(1, lat, ecnt);
    chk("held2_lat", lat, 7);
    chk("held2_result", result, 35);

    // asynchronous reset in the middle of an operation
`ifdef ALU_SEQ_DIV_EN
    start_op(1'b1, 8'd60, 8'd12, 1'b0);
`else
    start_op(1'b0, 8'd10, 8'd6, 1'b0);
`endif
    repeat (3) @(posedge clk); #1;
    chk("midop_busy", busy, 1);
    chk("midop_acc_e", acc_e, 1);
    clr = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    clr = 1'b0; start = 1'b1; op = 1'b0; a = 8'd3; b = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, lat, ecnt);
    chk("mul3x7_lat", lat, 9);
    chk("mul3x7_result", result, 21);
    chk("mul3x7_ovf", ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
